aes_sched: RTL and testbench
============================

AES_SCHED -- requirements
Module: aes_sched

Interface
REQ-001 Parameter: LAT, 21, core latency in clk cycles from input sample to valid core_out; legal range 2..63.
REQ-002 Parameter: CNT_W, 16, width of completion counters (used only with AES_SCHED_CNT_EN).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  issue enable; 0 blocks new grants, in-flight blocks still complete.
REQ-006 req0_valid / req1_valid  input  1  requester has a block to encrypt.
REQ-007 req0_ready / req1_ready  output  1  block accepted this cycle when ready&&valid.
REQ-008 req0_state / req1_state  input  128  plaintext block.
REQ-009 req0_key / req1_key  input  128  cipher key for that block.
REQ-010 core_state  output  128  plaintext to AES core.
REQ-011 core_key  output  128  key to AES core.
REQ-012 core_out  input  128  ciphertext from AES core.
REQ-013 rsp0_valid / rsp1_valid  output  1  one-cycle pulse, ciphertext for that requester on rsp_data.
REQ-014 rsp_data  output  128  registered copy of core_out, owner given by rsp0/1_valid.
REQ-015 busy  output  1  at least one block in flight.

Function
REQ-016 Grant: at most one requester per cycle; reqN_ready = en && grant==N; ready is 0 when en=0.
REQ-017 Arbitration: round-robin; one valid requester gets the grant; both valid -> requester not granted last gets it; last_grant updates only on a handshake.
REQ-018 Issue: on handshake core_state/core_key = the granted requester's state/key in the same cycle (combinational mux); otherwise both are 128'h0.
REQ-019 Tag pipe: {valid,id} shift register, LAT stages, shifted every cycle; stage 0 loads {handshake, granted id}.
REQ-020 Response: block accepted in cycle t -> rsp<id>_valid=1 and rsp_data=AES(state,key) in cycle t+LAT+1 (core LAT + 1 output register); exactly one rsp valid per accepted block.
REQ-021 Throughput: one block per cycle sustained; no backpressure on responses (consumers always accept).
REQ-022 Order: responses return in issue order; back-to-back accepts give back-to-back responses.
REQ-023 busy = OR of all tag-pipe valid bits and the output-register valid.
REQ-024 rsp_data holds its last value when no rsp valid is asserted.
REQ-025 en deassert mid-stream: no new grants; outstanding blocks drain and busy falls exactly LAT+1 cycles after the last accept.

Reset
REQ-026 rst=1 clears all tag-pipe valids, rsp0_valid=0, rsp1_valid=0, rsp_data=0, busy=0, last_grant=1 (req0 wins first tie).
REQ-027 While rst=1, req0_ready=req1_ready=0 and core_state=core_key=0.
REQ-028 Reset mid-operation drops in-flight blocks: no rsp valid for any block accepted before the reset, even though core_out keeps changing.

Configuration
REQ-029 Macro AES_SCHED_CNT_EN defined: add outputs cnt0, cnt1 (CNT_W each), counting rsp0_valid/rsp1_valid pulses, reset to 0, wrap from all-ones to 0.
REQ-030 AES_SCHED_CNT_EN undefined: cnt0/cnt1 ports and counter logic absent; all other behaviour identical.

Structure
REQ-031 Shared package aes_sched_pkg holds: AES_BLK_W=128, default LAT=21, req_id_t (1-bit requester id), tag_t {valid, req_id_t}.
REQ-032 One sub-module aes_sched_tagpipe (parameter LAT, tag_t in/out, clk, rst) implements the tag shift register; arbitration and muxing stay in aes_sched.

Verification
REQ-033 Single req0, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> rsp0_valid at accept+LAT+1, rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp1_valid never asserted.
REQ-034 Both requesters valid for 8 cycles after reset -> grants alternate 0,1,0,1,...; responses alternate the same way, back-to-back, 8 pulses in total.
REQ-035 Continuous req1 stream with en forced 0 for 3 cycles -> no ready in those cycles; 3-cycle gap in rsp1_valid exactly LAT+1 cycles later; busy tracks in-flight blocks.
REQ-036 Assert rst for 1 cycle with 5 blocks in flight -> no rsp valid afterwards for those blocks; busy=0 the cycle after reset; first tie after reset goes to req0.
REQ-037 With AES_SCHED_CNT_EN and CNT_W=4 -> 17 req0 blocks give cnt0=1 (wrapped), cnt1=0; without the macro the bench compiles without the cnt ports.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the two-requester AES core scheduler.
package aes_sched_pkg;

  localparam int unsigned AES_BLK_W   = 128;
  localparam int unsigned LAT_DEFAULT = 21;

  typedef logic [0:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/aes_sched_tagpipe.sv
// Tag shift register tracking which requester owns each block inside the AES core.
module aes_sched_tagpipe
  import aes_sched_pkg::*;
#(
  parameter int unsigned LAT = LAT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  tag_t tag_i,
  output tag_t tag_o,
  output logic any_valid_o
);

  tag_t pipe_q [LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(LAT); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < int'(LAT); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  always_comb begin
    any_valid_o = 1'b0;
    for (int i = 0; i < int'(LAT); i++) begin
      any_valid_o = any_valid_o | pipe_q[i].valid;
    end
  end

  assign tag_o = pipe_q[LAT-1];

endmodule

// File: rtl/aes_sched.sv
// Round-robin scheduler sharing one pipelined AES core between two requesters.
// Optional completion counters are built when AES_SCHED_CNT_EN is defined.
module aes_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned LAT = LAT_DEFAULT
`ifdef AES_SCHED_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 req0_valid_i,
  input  logic                 req1_valid_i,
  output logic                 req0_ready_o,
  output logic                 req1_ready_o,
  input  logic [AES_BLK_W-1:0] req0_state_i,
  input  logic [AES_BLK_W-1:0] req1_state_i,
  input  logic [AES_BLK_W-1:0] req0_key_i,
  input  logic [AES_BLK_W-1:0] req1_key_i,
  output logic [AES_BLK_W-1:0] core_state_o,
  output logic [AES_BLK_W-1:0] core_key_o,
  input  logic [AES_BLK_W-1:0] core_out_i,
  output logic                 rsp0_valid_o,
  output logic                 rsp1_valid_o,
  output logic [AES_BLK_W-1:0] rsp_data_o,
  output logic                 busy_o
`ifdef AES_SCHED_CNT_EN
  ,
  output logic [CNT_W-1:0]     cnt0_o,
  output logic [CNT_W-1:0]     cnt1_o
`endif
);

  logic                 gnt_vld;
  req_id_t              gnt_id;
  req_id_t              last_grant_q, last_grant_d;
  tag_t                 tag_in, tag_out;
  logic                 pipe_busy;
  logic                 rsp_vld_q, rsp_vld_d;
  req_id_t              rsp_id_q, rsp_id_d;
  logic [AES_BLK_W-1:0] rsp_data_q, rsp_data_d;

  // A grant only goes to a valid requester, so a grant is always a handshake.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    if (en_i && !rst_i) begin
      if (req0_valid_i && req1_valid_i) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_grant_q;
      end else if (req0_valid_i) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1_valid_i) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign req0_ready_o = gnt_vld && (gnt_id == 1'b0);
  assign req1_ready_o = gnt_vld && (gnt_id == 1'b1);

  always_comb begin
    core_state_o = '0;
    core_key_o   = '0;
    if (gnt_vld) begin
      core_state_o = gnt_id[0] ? req1_state_i : req0_state_i;
      core_key_o   = gnt_id[0] ? req1_key_i   : req0_key_i;
    end
  end

  always_comb begin
    tag_in.valid = gnt_vld;
    tag_in.id    = gnt_id;
  end

  aes_sched_tagpipe #(
    .LAT (LAT)
  ) u_tagpipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .tag_i       (tag_in),
    .tag_o       (tag_out),
    .any_valid_o (pipe_busy)
  );

  always_comb begin
    last_grant_d = last_grant_q;
    rsp_vld_d    = tag_out.valid;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    if (gnt_vld) begin
      last_grant_d = gnt_id;
    end
    if (tag_out.valid) begin
      rsp_id_d   = tag_out.id;
      rsp_data_d = core_out_i;
    end
  end

  // last_grant resets to 1 so that req0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
      rsp_vld_q    <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign rsp0_valid_o = rsp_vld_q && (rsp_id_q == 1'b0);
  assign rsp1_valid_o = rsp_vld_q && (rsp_id_q == 1'b1);
  assign rsp_data_o   = rsp_data_q;
  assign busy_o       = pipe_busy || rsp_vld_q;

`ifdef AES_SCHED_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (rsp0_valid_o) cnt0_d = cnt0_q + CNT_W'(1);
    if (rsp1_valid_o) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0_o = cnt0_q;
  assign cnt1_o = cnt1_q;
`endif

endmodule

// File: tb/tb_aes_sched.sv
// Bench for aes_sched: a behavioural LAT-deep core stand-in plus a response scoreboard.
// Build with AES_SCHED_CNT_EN defined to also check the 4-bit completion counters.
module tb_aes_sched;

  localparam int unsigned LAT = 21;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst, en, v0, v1;
  logic         req0_ready, req1_ready;
  logic [127:0] s0, s1, k0, k1;
  logic [127:0] core_state, core_key, core_out;
  logic         rsp0_valid, rsp1_valid, busy;
  logic [127:0] rsp_data;
`ifdef AES_SCHED_CNT_EN
  logic [3:0]   cnt0, cnt1;
`endif

  always #5 clk = ~clk;

  aes_sched #(
    .LAT (LAT)
`ifdef AES_SCHED_CNT_EN
    ,
    .CNT_W (4)
`endif
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .req0_valid_i (v0),
    .req1_valid_i (v1),
    .req0_ready_o (req0_ready),
    .req1_ready_o (req1_ready),
    .req0_state_i (s0),
    .req1_state_i (s1),
    .req0_key_i   (k0),
    .req1_key_i   (k1),
    .core_state_o (core_state),
    .core_key_o   (core_key),
    .core_out_i   (core_out),
    .rsp0_valid_o (rsp0_valid),
    .rsp1_valid_o (rsp1_valid),
    .rsp_data_o   (rsp_data),
    .busy_o       (busy)
`ifdef AES_SCHED_CNT_EN
    ,
    .cnt0_o       (cnt0),
    .cnt1_o       (cnt1)
`endif
  );

  // Stand-in core: the known-answer vector maps to its real ciphertext, anything else to a
  // cheap keyed mix. The scheduler never looks inside the data, only at its timing.
  function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
    if (pt == KAT_PT && key == KAT_KEY) return KAT_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a_0f0f_c3c3_9696_1234_5678_9abc_def0;
  endfunction

  logic [127:0] cpipe [LAT];
  always @(posedge clk) begin
    cpipe[0] <= core_fn(core_state, core_key);
    for (int i = 1; i < int'(LAT); i++) cpipe[i] <= cpipe[i-1];
  end
  assign core_out = cpipe[LAT-1];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  typedef struct {
    int           due;
    logic         id;
    logic [127:0] data;
  } exp_t;

  exp_t         sb [$];
  int           cyc = 0;
  int           last_acc = 0;
  logic         have_acc = 1'b0;
  logic         last_m = 1'b1;
  logic [127:0] last_data = '0;
  int           n0 = 0, n1 = 0;
  int           cnt0_m = 0, cnt1_m = 0;
  logic         exp_r0, exp_r1, exp_v0, exp_v1;
  logic [127:0] exp_cs, exp_ck, exp_d;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_r0 = !rst && en && v0 && (!v1 || last_m);
    exp_r1 = !rst && en && v1 && (!v0 || !last_m);
    chk("req0_ready", 128'(req0_ready), 128'(exp_r0));
    chk("req1_ready", 128'(req1_ready), 128'(exp_r1));
    exp_cs = exp_r0 ? s0 : (exp_r1 ? s1 : '0);
    exp_ck = exp_r0 ? k0 : (exp_r1 ? k1 : '0);
    chk("core_state", core_state, exp_cs);
    chk("core_key", core_key, exp_ck);

    exp_v0 = 1'b0;
    exp_v1 = 1'b0;
    exp_d  = last_data;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      if (sb[0].id) begin
        exp_v1 = 1'b1;
        cnt1_m++;
      end else begin
        exp_v0 = 1'b1;
        cnt0_m++;
      end
      exp_d = sb[0].data;
      void'(sb.pop_front());
    end
    chk("rsp0_valid", 128'(rsp0_valid), 128'(exp_v0));
    chk("rsp1_valid", 128'(rsp1_valid), 128'(exp_v1));
    chk("rsp_data", rsp_data, exp_d);
    last_data = exp_d;
    if (rsp0_valid) n0++;
    if (rsp1_valid) n1++;
    chk("busy", 128'(busy), 128'(have_acc && (cyc - last_acc <= int'(LAT) + 1)));
`ifdef AES_SCHED_CNT_EN
    chk("cnt0", 128'(cnt0), 128'(cnt0_m % 16));
    chk("cnt1", 128'(cnt1), 128'(cnt1_m % 16));
`endif

    if (rst) begin
      sb.delete();
      have_acc  = 1'b0;
      last_m    = 1'b1;
      last_data = '0;
      cnt0_m    = 0;
      cnt1_m    = 0;
    end else if (exp_r0 || exp_r1) begin
      sb.push_back('{due: cyc + int'(LAT) + 1, id: exp_r1, data: core_fn(exp_cs, exp_ck)});
      have_acc = 1'b1;
      last_acc = cyc;
      last_m   = exp_r1;
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_data();
    s0 = rnd128();
    k0 = rnd128();
    s1 = rnd128();
    k1 = rnd128();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) step();
    repeat (3) step();
    chk(tag, 128'(sb.size()), 128'(0));
  endtask

  int b0, b1;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    v0  = 1'b0;
    v1  = 1'b0;
    s0  = '0;
    s1  = '0;
    k0  = '0;
    k1  = '0;
    repeat (3) step();
    rst = 1'b0;
    en  = 1'b1;
    step();

    // Single known-answer block from req0.
    b0 = n0;
    b1 = n1;
    s0 = KAT_PT;
    k0 = KAT_KEY;
    v0 = 1'b1;
    step();
    v0 = 1'b0;
    drain("kat_drain");
    chk("kat_rsp0_cnt", 128'(n0 - b0), 128'(1));
    chk("kat_rsp1_cnt", 128'(n1 - b1), 128'(0));
    chk("kat_hold", rsp_data, KAT_CT);

    // Both requesters valid for 8 cycles: alternating grants and responses.
    do_reset();
    b0 = n0;
    b1 = n1;
    for (int i = 0; i < 8; i++) begin
      v0 = 1'b1;
      v1 = 1'b1;
      randomize_data();
      step();
    end
    v0 = 1'b0;
    v1 = 1'b0;
    drain("rr_drain");
    chk("rr_rsp0_cnt", 128'(n0 - b0), 128'(4));
    chk("rr_rsp1_cnt", 128'(n1 - b1), 128'(4));

    // Continuous req1 stream with a 3-cycle enable gap.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      v1 = 1'b1;
      en = !(i >= 6 && i < 9);
      randomize_data();
      step();
    end
    en = 1'b1;
    v1 = 1'b0;
    drain("gap_drain");

    // Reset with 5 blocks in flight, then a tie that must go to req0.
    for (int i = 0; i < 5; i++) begin
      v0 = 1'b1;
      v1 = 1'b1;
      randomize_data();
      step();
    end
    v0  = 1'b0;
    v1  = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", 128'(busy), 128'(0));
    v0 = 1'b1;
    v1 = 1'b1;
    randomize_data();
    #1;
    chk("rst_tie_r0", 128'(req0_ready), 128'(1));
    chk("rst_tie_r1", 128'(req1_ready), 128'(0));
    step();
    v0 = 1'b0;
    v1 = 1'b0;
    drain("rst_drain");

    // 17 req0 blocks: a 4-bit counter wraps to 1.
    do_reset();
    b0 = n0;
    for (int i = 0; i < 17; i++) begin
      v0 = 1'b1;
      randomize_data();
      step();
    end
    v0 = 1'b0;
    drain("wrap_drain");
    chk("wrap_rsp0_cnt", 128'(n0 - b0), 128'(17));
`ifdef AES_SCHED_CNT_EN
    chk("cnt0_wrap", 128'(cnt0), 128'(1));
    chk("cnt1_zero", 128'(cnt1), 128'(0));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
